// File: rtl/switch_debouncer.sv
// Two-flop synchronised, per-channel FSM debouncer for slide switches.
// Define SWITCH_DEBOUNCER_BYPASS_EN to compile out the wait/count stage (simulation only).
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             settled
);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Bring the asynchronous switch levels into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

`ifndef SWITCH_DEBOUNCER_BYPASS_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] waiting;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          clean_q;
    logic          rise_q;
    logic          fall_q;

    // Accept a new level only after it holds for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= STABLE_LO;
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        unique case (state)
          STABLE_LO: begin
            if (sync2[i]) begin
              state <= WAIT_HI;
              cnt   <= '0;
            end
          end
          WAIT_HI: begin
            if (!sync2[i]) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state   <= STABLE_HI;
              cnt     <= '0;
              clean_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STABLE_HI: begin
            if (!sync2[i]) begin
              state <= WAIT_LO;
              cnt   <= '0;
            end
          end
          WAIT_LO: begin
            if (sync2[i]) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state   <= STABLE_LO;
              cnt     <= '0;
              clean_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign waiting[i]  = (state == WAIT_HI) || (state == WAIT_LO);
    assign sw_clean[i] = clean_q;
    assign sw_rise[i]  = rise_q;
    assign sw_fall[i]  = fall_q;
  end

  // Quiet indication: no channel is mid-debounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settled <= 1'b1;
    end else begin
      settled <= ~|waiting;
    end
  end

`else

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t state;
    logic   clean_q;
    logic   rise_q;
    logic   fall_q;

    // Follow the synchronised level directly, still emitting edge pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= STABLE_LO;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        unique case (state)
          STABLE_LO: begin
            if (sync2[i]) begin
              state   <= STABLE_HI;
              clean_q <= 1'b1;
              rise_q  <= 1'b1;
            end
          end
          STABLE_HI: begin
            if (!sync2[i]) begin
              state   <= STABLE_LO;
              clean_q <= 1'b0;
              fall_q  <= 1'b1;
            end
          end
          default: begin
            state <= STABLE_LO;
          end
        endcase
      end
    end

    assign sw_clean[i] = clean_q;
    assign sw_rise[i]  = rise_q;
    assign sw_fall[i]  = fall_q;
  end

  // Nothing ever waits in this build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settled <= 1'b1;
    end else begin
      settled <= 1'b1;
    end
  end

`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer, DEBOUNCE_CYCLES=4, WIDTH=8.
// Each scenario task checks its own expectations inline.
module tb_switch_debouncer;

  logic       clk;
  logic       rst;
  logic [7:0] sw_raw;
  logic [7:0] sw_clean;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       settled;

  int errors = 0;
  int checks = 0;

  switch_debouncer #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .settled(settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sw_raw = 8'hFF;
    #1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (sw_clean !== 8'h00 || sw_rise !== 8'h00 ||
          sw_fall !== 8'h00 || settled !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: clean=%h rise=%h fall=%h settled=%b want 00 00 00 1",
                 n, sw_clean, sw_rise, sw_fall, settled);
      end
      tick();
    end
    rst    = 1'b0;
    sw_raw = 8'h00;
    tick();
    checks++;
    if (settled !== 1'b1 || sw_clean !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: clean=%h settled=%b want 00 1", sw_clean, settled);
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  // n-th tick after driving observes edge k+n-1; accept at k+6 -> n=7.
  task automatic test_clean_rise();
    logic ec;
    logic er;
    logic ef;
    logic es;
    sw_raw[0] = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n >= 7);
      er = (n == 7);
      es = !(n >= 4 && n <= 7);
      checks++;
      if (sw_clean[0] !== ec || sw_rise[0] !== er ||
          sw_fall[0] !== 1'b0 || settled !== es) begin
        errors++;
        $display("FAIL rise[n=%0d]: clean=%b rise=%b fall=%b settled=%b want %b %b 0 %b",
                 n, sw_clean[0], sw_rise[0], sw_fall[0], settled, ec, er, es);
      end
    end
    sw_raw[0] = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n < 7);
      ef = (n == 7);
      es = !(n >= 4 && n <= 7);
      checks++;
      if (sw_clean[0] !== ec || sw_fall[0] !== ef ||
          sw_rise[0] !== 1'b0 || settled !== es) begin
        errors++;
        $display("FAIL fall[n=%0d]: clean=%b rise=%b fall=%b settled=%b want %b 0 %b %b",
                 n, sw_clean[0], sw_rise[0], sw_fall[0], settled, ec, ef, es);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    logic       saw_low;
    pat     = 4'b0101;
    saw_low = 1'b0;
    for (int n = 0; n < 14; n++) begin
      sw_raw[3] = (n < 4) ? pat[n] : 1'b0;
      tick();
      if (settled === 1'b0) saw_low = 1'b1;
      checks++;
      if (sw_clean !== 8'h00 || sw_rise !== 8'h00 || sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL bounce[%0d]: clean=%h rise=%h fall=%h want 00 00 00",
                 n, sw_clean, sw_rise, sw_fall);
      end
    end
    checks++;
    if (saw_low !== 1'b1 || settled !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settled: dipped=%b final=%b want 1 1", saw_low, settled);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] ec;
    logic [7:0] ep;
    sw_raw = 8'hA5;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n >= 7) ? 8'hA5 : 8'h00;
      ep = (n == 7) ? 8'hA5 : 8'h00;
      checks++;
      if (sw_clean !== ec || sw_rise !== ep || sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL simul_rise[n=%0d]: clean=%h rise=%h fall=%h want %h %h 00",
                 n, sw_clean, sw_rise, sw_fall, ec, ep);
      end
    end
    sw_raw = 8'h00;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n >= 7) ? 8'h00 : 8'hA5;
      ep = (n == 7) ? 8'hA5 : 8'h00;
      checks++;
      if (sw_clean !== ec || sw_fall !== ep || sw_rise !== 8'h00) begin
        errors++;
        $display("FAIL simul_fall[n=%0d]: clean=%h rise=%h fall=%h want %h 00 %h",
                 n, sw_clean, sw_rise, sw_fall, ec, ep);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic ec;
    logic er;
    logic es;
    sw_raw[7] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (sw_clean !== 8'h00 || sw_rise !== 8'h00 ||
          sw_fall !== 8'h00 || settled !== 1'b1) begin
        errors++;
        $display("FAIL midrst[%0d]: clean=%h rise=%h fall=%h settled=%b want 00 00 00 1",
                 n, sw_clean, sw_rise, sw_fall, settled);
      end
      tick();
    end
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n >= 7);
      er = (n == 7);
      es = !(n >= 4 && n <= 7);
      checks++;
      if (sw_clean[7] !== ec || sw_rise[7] !== er || settled !== es ||
          sw_fall !== 8'h00) begin
        errors++;
        $display("FAIL redebounce[n=%0d]: clean=%b rise=%b settled=%b fall=%h want %b %b %b 00",
                 n, sw_clean[7], sw_rise[7], settled, sw_fall, ec, er, es);
      end
    end
  endtask

  task automatic test_bypass();
    logic ec;
    logic er;
    logic ef;
    sw_raw[2] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      sw_raw[2] = 1'b0;
      ec = (n == 3);
      er = (n == 3);
      ef = (n == 4);
      checks++;
      if (sw_clean[2] !== ec || sw_rise[2] !== er ||
          sw_fall[2] !== ef || settled !== 1'b1) begin
        errors++;
        $display("FAIL bypass[n=%0d]: clean=%b rise=%b fall=%b settled=%b want %b %b %b 1",
                 n, sw_clean[2], sw_rise[2], sw_fall[2], settled, ec, er, ef);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = 8'h00;
    test_reset();
`ifdef SWITCH_DEBOUNCER_BYPASS_EN
    test_bypass();
`else
    test_clean_rise();
    test_bounce();
    test_simultaneous();
    test_reset_mid_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
